// File: rtl/fifo_push_ctrl.sv
// Write-side push sequencer for the 2-entry async FIFO (wclk domain).
// Turns accepted burst requests into paced, full-respecting push pulses.
module fifo_push_ctrl #(
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned GAP       = 1,
    parameter int unsigned STALL_MAX = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             wclk,
    input  logic             wreset_n,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             abort,
    input  logic             full,
    output logic             push,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             stall_err,
    output logic [CNT_W-1:0] push_count
);

    localparam int unsigned GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [STALL_W-1:0] STALL_TOP  = STALL_W'(STALL_MAX);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_WAIT = 5'b00010,
        S_PUSH = 5'b00100,
        S_GAP  = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_W-1:0]     r_remaining;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic                 r_aborted;
    logic                 r_stall_err;
    logic [CNT_W-1:0]     r_push_count;

    logic                 w_gap_last;
    logic                 w_more_after_push;
    logic                 w_abort_exit;
    logic                 w_wait_hold;

    assign w_gap_last        = (r_gap_cnt == GAP_LAST);
    // r_remaining still includes the push in flight while in PUSH
    assign w_more_after_push = (r_remaining > LEN_W'(1));
    assign w_abort_exit      = abort && ((r_state == S_WAIT) || (r_state == S_PUSH) ||
                                         (r_state == S_GAP));
    assign w_wait_hold       = (r_state == S_WAIT) && (w_state_nxt == S_WAIT);

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (req_len != '0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (!full) begin
                    w_state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (GAP > 0) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_state_nxt = w_more_after_push ? S_WAIT : S_DONE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (w_gap_last) begin
                    w_state_nxt = (r_remaining != '0) ? S_WAIT : S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        push       = (r_state == S_PUSH);
        busy       = (r_state == S_WAIT) || (r_state == S_PUSH) || (r_state == S_GAP);
        done       = (r_state == S_DONE);
        aborted    = r_aborted;
        stall_err  = r_stall_err;
        push_count = r_push_count;
    end

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            r_remaining  <= '0;
            r_push_count <= '0;
        end else if ((r_state == S_IDLE) && req_valid) begin
            r_remaining  <= req_len;
        end else if (r_state == S_PUSH) begin
            r_remaining  <= r_remaining - LEN_W'(1);
            r_push_count <= r_push_count + CNT_W'(1);
        end
    end

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // Only edges that keep the burst waiting on full count towards the stall limit
    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else if (w_wait_hold) begin
            if (r_stall_cnt != STALL_TOP) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
            if (r_stall_cnt == STALL_LAST) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= (w_state_nxt == S_DONE) && w_abort_exit;
        end
    end

endmodule

// File: tb/tb_fifo_push_ctrl.sv
// Bench for fifo_push_ctrl: cycle table, directed corner sequences and
// random traffic against a timestamp-based burst model.
module tb_fifo_push_ctrl;

    localparam int unsigned LEN_W     = 4;
    localparam int unsigned GAP       = 1;
    localparam int unsigned STALL_MAX = 64;
    localparam int unsigned CNT_W     = 8;

    logic             wclk = 1'b0;
    logic             wreset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic [LEN_W-1:0] req_len = '0;
    logic             req_ready;
    logic             abort = 1'b0;
    logic             full = 1'b0;
    logic             push;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             stall_err;
    logic [CNT_W-1:0] push_count;

    always #5 wclk = ~wclk;

    fifo_push_ctrl #(
        .LEN_W(LEN_W),
        .GAP(GAP),
        .STALL_MAX(STALL_MAX),
        .CNT_W(CNT_W)
    ) dut (
        .wclk(wclk),
        .wreset_n(wreset_n),
        .req_valid(req_valid),
        .req_len(req_len),
        .req_ready(req_ready),
        .abort(abort),
        .full(full),
        .push(push),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .stall_err(stall_err),
        .push_count(push_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Burst model: a burst is described by timestamps (cycle of the latest push,
    // first cycle it samples full again, cycle of its done) rather than states.
    int t, m_push_c, m_wait_s, m_done_c, m_rem, m_run, m_cnt;
    bit m_burst, m_ab, m_err, m_full_edge;
    bit e_ready, e_push, e_busy, e_done, e_ab;
    bit chk_on = 1'b0;

    task automatic model_reset();
        m_burst = 0; m_push_c = -10; m_wait_s = 0; m_done_c = -10;
        m_rem = 0; m_run = 0; m_cnt = 0; m_ab = 0; m_err = 0; m_full_edge = 0;
    endtask

    task automatic end_burst(input bit ab);
        m_burst = 0; m_done_c = t; m_ab = ab; m_run = 0;
    endtask

    task automatic model_expect();
        e_done  = (t == m_done_c);
        e_push  = m_burst && (t == m_push_c);
        e_busy  = m_burst;
        e_ready = !m_burst && !e_done;
        e_ab    = m_ab;
    endtask

    initial begin : model
        bit was_push, was_wait, was_gap, was_done, was_idle;
        int p;
        t = 0;
        model_reset();
        model_expect();
        forever begin
            @(posedge wclk or negedge wreset_n);
            if (!wreset_n) begin
                model_reset();
            end else begin
                t++;
                p = t - 1;
                was_done = (p == m_done_c);
                was_push = m_burst && (p == m_push_c);
                was_wait = m_burst && !was_push && (p >= m_wait_s);
                was_gap  = m_burst && !was_push && !was_wait;
                was_idle = !m_burst && !was_done;
                m_full_edge = full;
                if (was_idle && req_valid) begin
                    if (req_len == 0) begin
                        m_done_c = t; m_ab = 0;
                    end else begin
                        m_burst = 1; m_rem = int'(req_len); m_wait_s = t; m_run = 0;
                    end
                end else if (was_wait) begin
                    if (abort) end_burst(1);
                    else if (!full) begin
                        m_push_c = t; m_rem--; m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run >= STALL_MAX) m_err = 1;
                    end
                end else if (was_push) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    if (abort) end_burst(1);
                    else m_wait_s = t + GAP;
                end else if (was_gap && abort) begin
                    end_burst(1);
                end
                if (m_burst && t == m_wait_s && m_push_c != t && m_rem == 0) end_burst(0);
            end
            model_expect();
        end
    end

    always @(negedge wclk) begin
        if (chk_on) begin
            check("model_ready", req_ready, e_ready);
            check("model_push", push, e_push);
            check("model_busy", busy, e_busy);
            check("model_done", done, e_done);
            if (e_done) check("model_aborted", aborted, e_ab);
            check("model_stall_err", stall_err, m_err);
            check("model_push_count", push_count, m_cnt);
            if (push) check("protocol_full_at_prev_edge", m_full_edge, 0);
        end
    end

    typedef struct {
        logic       v;
        int         l;
        logic       ab;
        logic       f;
        logic [4:0] e;     // {ready, push, busy, done, aborted}
        int         cnt;
    } vec_t;

    localparam logic [4:0] E_IDLE = 5'b10000;
    localparam logic [4:0] E_WAIT = 5'b00100;
    localparam logic [4:0] E_PUSH = 5'b01100;
    localparam logic [4:0] E_GAP  = 5'b00100;
    localparam logic [4:0] E_DONE = 5'b00010;
    localparam logic [4:0] E_DAB  = 5'b00011;

    function automatic vec_t mk(input logic v, input int l, input logic ab, input logic f,
                                input logic [4:0] e, input int cnt);
        vec_t r;
        r.v = v; r.l = l; r.ab = ab; r.f = f; r.e = e; r.cnt = cnt;
        return r;
    endfunction

    vec_t tbl[35];

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge wclk); #1;
            n++;
        end
        check(name, done, 1);
    endtask

    task automatic run_burst(input int len);
        int n = 0;
        @(negedge wclk);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge wclk);
            n++;
        end
        check("burst_ready", req_ready, 1);
        req_valid = 1'b1; req_len = LEN_W'(len); full = 1'b0; abort = 1'b0;
        @(negedge wclk);
        req_valid = 1'b0;
        wait_done("burst_done");
    endtask

    initial begin
        // inputs for each row are held during the cycle before the edge it checks
        tbl[0]  = mk(1, 3, 0, 0, E_WAIT, 0);
        tbl[1]  = mk(0, 0, 0, 0, E_PUSH, 0);
        tbl[2]  = mk(0, 0, 0, 0, E_GAP,  1);
        tbl[3]  = mk(0, 0, 0, 0, E_WAIT, 1);
        tbl[4]  = mk(0, 0, 0, 0, E_PUSH, 1);
        tbl[5]  = mk(0, 0, 0, 0, E_GAP,  2);
        tbl[6]  = mk(0, 0, 0, 0, E_WAIT, 2);
        tbl[7]  = mk(0, 0, 0, 0, E_PUSH, 2);
        tbl[8]  = mk(1, 7, 0, 0, E_GAP,  3);
        tbl[9]  = mk(1, 7, 0, 0, E_DONE, 3);
        tbl[10] = mk(1, 7, 0, 0, E_IDLE, 3);
        tbl[11] = mk(1, 0, 0, 0, E_DONE, 3);
        tbl[12] = mk(0, 0, 0, 0, E_IDLE, 3);
        tbl[13] = mk(1, 5, 0, 0, E_WAIT, 3);
        tbl[14] = mk(0, 0, 0, 0, E_PUSH, 3);
        tbl[15] = mk(0, 0, 0, 0, E_GAP,  4);
        tbl[16] = mk(0, 0, 0, 0, E_WAIT, 4);
        tbl[17] = mk(0, 0, 0, 0, E_PUSH, 4);
        tbl[18] = mk(0, 0, 0, 0, E_GAP,  5);
        tbl[19] = mk(0, 0, 1, 0, E_DAB,  5);
        tbl[20] = mk(0, 0, 0, 0, E_IDLE, 5);
        tbl[21] = mk(1, 4, 0, 0, E_WAIT, 5);
        tbl[22] = mk(0, 0, 0, 0, E_PUSH, 5);
        tbl[23] = mk(0, 0, 1, 0, E_DAB,  6);
        tbl[24] = mk(0, 0, 0, 0, E_IDLE, 6);
        tbl[25] = mk(1, 2, 0, 0, E_WAIT, 6);
        tbl[26] = mk(0, 0, 1, 0, E_DAB,  6);
        tbl[27] = mk(0, 0, 0, 0, E_IDLE, 6);
        tbl[28] = mk(1, 1, 0, 1, E_WAIT, 6);
        tbl[29] = mk(0, 0, 0, 1, E_WAIT, 6);
        tbl[30] = mk(0, 0, 0, 0, E_PUSH, 6);
        tbl[31] = mk(0, 0, 0, 0, E_GAP,  7);
        tbl[32] = mk(0, 0, 0, 0, E_DONE, 7);
        tbl[33] = mk(0, 0, 1, 0, E_IDLE, 7);
        tbl[34] = mk(0, 0, 1, 0, E_IDLE, 7);

        repeat (2) @(posedge wclk);
        #1;
        check("reset_ready", req_ready, 1);
        check("reset_push", push, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_aborted", aborted, 0);
        check("reset_stall_err", stall_err, 0);
        check("reset_push_count", push_count, 0);
        @(negedge wclk); #2;
        wreset_n = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 35; i++) begin
            @(negedge wclk);
            req_valid = tbl[i].v; req_len = LEN_W'(tbl[i].l);
            abort = tbl[i].ab; full = tbl[i].f;
            @(posedge wclk); #1;
            check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e[4]);
            check($sformatf("tbl%0d_push", i), push, tbl[i].e[3]);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e[2]);
            check($sformatf("tbl%0d_done", i), done, tbl[i].e[1]);
            check($sformatf("tbl%0d_aborted", i), aborted, tbl[i].e[0]);
            check($sformatf("tbl%0d_count", i), push_count, tbl[i].cnt);
        end
        @(negedge wclk);
        req_valid = 1'b0; abort = 1'b0; full = 1'b0;

        // back-pressure: full high for the 10 cycles starting at acceptance
        @(negedge wclk);
        req_valid = 1'b1; req_len = 4'd2; full = 1'b1;
        @(posedge wclk); #1;
        check("bp_accepted", busy, 1);
        @(negedge wclk);
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge wclk); #1;
            check($sformatf("bp_no_push_%0d", k), push, 0);
        end
        @(negedge wclk);
        full = 1'b0;
        @(posedge wclk); #1;
        check("bp_first_push", push, 1);
        wait_done("bp_done");
        check("bp_stall_err", stall_err, 0);
        check("bp_count", push_count, 9);

        // stall: full high for 70 cycles
        @(negedge wclk);
        @(negedge wclk);
        req_valid = 1'b1; req_len = 4'd1; full = 1'b1;
        @(posedge wclk); #1;
        @(negedge wclk);
        req_valid = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge wclk); #1;
            if (k == 63) check("stall_err_before_limit", stall_err, 0);
            if (k == 64) check("stall_err_at_limit", stall_err, 1);
            if (k == 70) check("stall_err_held", stall_err, 1);
        end
        @(negedge wclk);
        full = 1'b0;
        wait_done("stall_done");
        check("stall_aborted", aborted, 0);
        check("stall_err_sticky", stall_err, 1);
        check("stall_count", push_count, 10);

        // reset mid-burst during a push cycle
        @(negedge wclk);
        @(negedge wclk);
        req_valid = 1'b1; req_len = 4'd5;
        @(negedge wclk);
        req_valid = 1'b0;
        begin
            int n = 0;
            while (push !== 1'b1 && n < 50) begin
                @(posedge wclk); #1;
                n++;
            end
            check("rst_saw_push", push, 1);
        end
        #2;
        wreset_n = 1'b0;
        #1;
        check("rst_async_push", push, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_ready", req_ready, 1);
        check("rst_async_done", done, 0);
        check("rst_async_stall_err", stall_err, 0);
        check("rst_async_count", push_count, 0);
        @(negedge wclk); #2;
        wreset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge wclk); #1;
            check("rst_no_done", done, 0);
        end

        // push_count wrap at 2^CNT_W
        for (int b = 0; b < 17; b++) run_burst(15);
        check("wrap_pre", push_count, 255);
        run_burst(1);
        check("wrap_zero", push_count, 0);

        // random traffic with occasional reset pulses
        for (int i = 0; i < 4000; i++) begin
            @(negedge wclk);
            req_valid = ($urandom_range(0, 3) != 0);
            req_len   = LEN_W'($urandom_range(0, 15));
            abort     = ($urandom_range(0, 29) == 0);
            full      = (i % 700 < 90) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                wreset_n = 1'b0;
                @(posedge wclk); #2;
                wreset_n = 1'b1;
            end
        end
        @(negedge wclk);
        req_valid = 1'b0; abort = 1'b0; full = 1'b0;
        repeat (4) @(negedge wclk);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_push_ctrl.md
# fifo_push_ctrl

Write-side push sequencer sitting directly upstream of the 2-entry async FIFO in the `wclk` domain. It accepts burst requests from a producer over a valid/ready handshake and converts each into a paced train of single-cycle `push` pulses. Every pulse obeys the FIFO write protocol: `push` is high only if `full` was low at the previous `wclk` edge. It also reports completion and aborts, flags sustained back-pressure, and keeps a running push count.

## Interface
- `LEN_W`, 4, width of the burst length field.
- `GAP`, 1, idle cycles inserted after each push; legal range is 0 or greater.
- `STALL_MAX`, 64, consecutive WAIT cycles with `full`=1 before `stall_err` sets; must be 1 or greater.
- `CNT_W`, 16, width of `push_count`.
- `wclk`  in  1  write-domain clock; the block's only clock.
- `wreset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  burst request valid.
- `req_len`  in  LEN_W  number of pushes in the burst; 0 is a legal no-op.
- `req_ready`  out  1  block idle and accepting a request.
- `abort`  in  1  terminate the current burst early.
- `full`  in  1  FIFO full, from the FIFO write side.
- `push`  out  1  FIFO write strobe.
- `busy`  out  1  burst in progress.
- `done`  out  1  single-cycle pulse at burst end.
- `aborted`  out  1  qualifies `done`: the burst was cut short.
- `stall_err`  out  1  sticky back-pressure error.
- `push_count`  out  CNT_W  total pushes since reset.

## Operation
- Reset values (`wreset_n` low, asynchronous): state=IDLE, `req_ready`=1, `push`=0, `busy`=0, `done`=0, `aborted`=0, `stall_err`=0, `push_count`=0, internal counters 0.
- All outputs are registered or decoded from one-hot state flops. No combinational path from any input to any output.
- States: IDLE, WAIT, PUSH, GAP, DONE.
- IDLE:
  - `req_ready`=1.
  - On an edge with `req_valid`=1, latch `req_len` into `remaining`.
  - Go to WAIT if `req_len`≠0, otherwise go to DONE.
- WAIT:
  - At an edge with `full`=0, go to PUSH.
  - With `full`=1, stay and increment `stall_cnt`. `stall_cnt` saturates at STALL_MAX.
  - `stall_cnt` reaching STALL_MAX sets `stall_err`. `stall_err` holds until reset; the burst keeps waiting.
  - `stall_cnt` clears on leaving WAIT.
- PUSH:
  - Lasts exactly one cycle, with `push`=1.
  - On exit: decrement `remaining` and increment `push_count`. `push_count` wraps modulo 2^CNT_W.
  - Next state is GAP if GAP>0. Otherwise it is WAIT if `remaining`>0, else DONE.
- GAP:
  - Lasts exactly GAP cycles.
  - Then go to WAIT if `remaining`>0, else DONE.
- DONE:
  - Lasts one cycle, with `done`=1; `aborted` is valid in this cycle.
  - Then return to IDLE.
- `busy`=1 in WAIT, PUSH and GAP.
- Abort:
  - Sampled in WAIT or GAP: go to DONE with `aborted`=1. No further push is issued.
  - Asserted in PUSH: the push completes and is counted, then go to DONE with `aborted`=1.
  - Ignored in IDLE and DONE.
  - An abort takes priority over a `full`=0 transition out of WAIT at the same edge.
- Requests are not queued. `req_valid` outside IDLE is ignored, and the producer holds it until accepted.
- Reset mid-burst: all state is discarded immediately. `push` drops asynchronously. No `done` is issued.

## Timing
- Let the acceptance edge be a.
  - WAIT is entered at a.
  - The earliest `push` is the cycle starting at a+1.
- Push period with `full`=0 is GAP+2 cycles: PUSH, then GAP cycles, then one WAIT sampling cycle.
- Each WAIT→PUSH decision samples `full` after the FIFO has already registered the previous push. This is what guarantees `push` implies that `full` was 0 at the previous edge.
- The last push is followed by GAP cycles, then DONE; `req_ready` returns the cycle after DONE.
- A zero-length request gives DONE at a+1 and IDLE at a+2, with no push.
- Back-to-back `push` cycles never occur.

## Test plan
- Basic burst: GAP=1, `req_len`=3, `full`=0 throughout, acceptance edge a.
  - `push` is high for cycles a+1, a+4 and a+7.
  - `done`=1, `aborted`=0 at a+9.
  - `push_count`=3; `req_ready`=1 at a+10.
- Back-pressure: `req_len`=2, `full` held high for 10 cycles after acceptance.
  - No push occurs while `full` is high.
  - The first push comes in the cycle after the first edge that samples `full`=0.
  - `stall_err` stays 0.
- Stall: STALL_MAX=64, `full` held high for 70 cycles.
  - `stall_err` rises after exactly 64 WAIT cycles and stays 1.
  - The burst completes after `full` falls.
- Abort: `req_len`=5, `abort` pulsed one cycle during the GAP after the 2nd push.
  - The next cycle is DONE with `aborted`=1.
  - `push_count`=2.
- Edge cases:
  - `req_len`=0 gives a `done` pulse at a+1 and no push.
  - `push_count` preloaded near 2^CNT_W−1 wraps to 0.
- Protocol check on random traffic: a bench assertion that `push` implies `$past(full)==0` never fires. `wreset_n` pulsed low mid-burst forces every output to its reset value immediately.
